// File: rtl/adder_seq_pkg.sv
// Shared types and elaboration helpers for the sequential slice adder.
package adder_seq_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic int n_slices(input int width, input int slice);
        return width / slice;
    endfunction

    // Index width for n slices; a single slice still needs a 1-bit index.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adder_seq_nb_slice.sv
// Combinational SLICE-bit ripple adder; also exposes the carry into its MSB for overflow.
module adder_slice #(
    parameter int SLICE = 2
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             c_in,
    output logic [SLICE-1:0] s,
    output logic             c_out,
    output logic             c_msb_in
);

    logic [SLICE:0] carry_s;

    // Bit-serial ripple through the slice.
    always_comb begin
        carry_s    = '0;
        s          = '0;
        carry_s[0] = c_in;
        for (int i = 0; i < SLICE; i++) begin
            s[i]         = a[i] ^ b[i] ^ carry_s[i];
            carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
        end
    end

    assign c_out    = carry_s[SLICE];
    assign c_msb_in = carry_s[SLICE-1];

endmodule

// File: rtl/adder_seq_nb.sv
// Multi-cycle WIDTH-bit adder, SLICE bits per clock, start/ready/done handshake.
// Optional macro ADDER_SEQ_SUB_EN adds a 'sub' port for a - b - cin.
module adder_seq_nb
    import adder_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef ADDER_SEQ_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = n_slices(WIDTH, SLICE);
    localparam int IW = idx_w(N);

    if (WIDTH < 1 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_param_check
        $error("adder_seq_nb: SLICE must be >= 1 and divide WIDTH");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             cout_q, cout_d, ovf_q, ovf_d, done_q, done_d;

    logic [WIDTH-1:0] b_in_s;
    logic             cin_in_s;
    logic [SLICE-1:0] a_slice_s, b_slice_s, s_slice_s;
    logic             c_out_s, c_msb_s, last_s;

    // Subtraction is a + ~b + ~cin, so only the loaded operand and carry differ.
`ifdef ADDER_SEQ_SUB_EN
    assign b_in_s   = sub ? ~b : b;
    assign cin_in_s = sub ? ~cin : cin;
`else
    assign b_in_s   = b;
    assign cin_in_s = cin;
`endif

    assign a_slice_s = a_q[int'(idx_q)*SLICE +: SLICE];
    assign b_slice_s = b_q[int'(idx_q)*SLICE +: SLICE];
    assign last_s    = (idx_q == IW'(N - 1));

    adder_slice #(.SLICE(SLICE)) u_slice (
        .a        (a_slice_s),
        .b        (b_slice_s),
        .c_in     (carry_q),
        .s        (s_slice_s),
        .c_out    (c_out_s),
        .c_msb_in (c_msb_s)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
                else       state_d = IDLE;
            end
            RUN: begin
                if (last_s) state_d = IDLE;
                else        state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and result register updates.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b_in_s;
                    carry_d = cin_in_s;
                    idx_d   = '0;
                    sum_d   = '0;
                end else begin
                    done_d  = 1'b0;
                end
            end
            RUN: begin
                sum_d[int'(idx_q)*SLICE +: SLICE] = s_slice_s;
                carry_d = c_out_s;
                if (last_s) begin
                    cout_d = c_out_s;
                    ovf_d  = c_out_s ^ c_msb_s;
                    done_d = 1'b1;
                    idx_d  = '0;
                end else begin
                    idx_d  = idx_q + IW'(1);
                end
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    assign ready = (state_q == IDLE);
    assign done  = done_q;
    assign sum   = sum_q;
    assign cout  = cout_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_adder_seq_nb.sv
// Self-checking bench: vector table, handshake/reset sequences, random ops and a 4-bit sweep.
module tb_adder_seq_nb;

    localparam int N = 4;

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, cin = 1'b0, sub = 1'b0;
    logic [7:0] a = 8'h00, b = 8'h00;
    logic       ready, done, cout, ovf;
    logic [7:0] sum;

    logic       s4_start = 1'b0, s4_cin = 1'b0, s4_sub = 1'b0;
    logic [3:0] s4_a = 4'h0, s4_b = 4'h0;
    logic       w_ready [3];
    logic       w_done  [3];
    logic       w_cout  [3];
    logic       w_ovf   [3];
    logic [3:0] w_sum   [3];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    adder_seq_nb #(.WIDTH(8), .SLICE(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
`ifdef ADDER_SEQ_SUB_EN
        .sub(sub),
`endif
        .a(a), .b(b), .cin(cin), .ready(ready), .done(done),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    adder_seq_nb #(.WIDTH(4), .SLICE(1)) dut4_s1 (
        .clk(clk), .rst_n(rst_n), .start(s4_start),
`ifdef ADDER_SEQ_SUB_EN
        .sub(s4_sub),
`endif
        .a(s4_a), .b(s4_b), .cin(s4_cin), .ready(w_ready[0]), .done(w_done[0]),
        .sum(w_sum[0]), .cout(w_cout[0]), .ovf(w_ovf[0])
    );

    adder_seq_nb #(.WIDTH(4), .SLICE(2)) dut4_s2 (
        .clk(clk), .rst_n(rst_n), .start(s4_start),
`ifdef ADDER_SEQ_SUB_EN
        .sub(s4_sub),
`endif
        .a(s4_a), .b(s4_b), .cin(s4_cin), .ready(w_ready[1]), .done(w_done[1]),
        .sum(w_sum[1]), .cout(w_cout[1]), .ovf(w_ovf[1])
    );

    adder_seq_nb #(.WIDTH(4), .SLICE(4)) dut4_s4 (
        .clk(clk), .rst_n(rst_n), .start(s4_start),
`ifdef ADDER_SEQ_SUB_EN
        .sub(s4_sub),
`endif
        .a(s4_a), .b(s4_b), .cin(s4_cin), .ready(w_ready[2]), .done(w_done[2]),
        .sum(w_sum[2]), .cout(w_cout[2]), .ovf(w_ovf[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference from arithmetic: {ovf, cout, sum[7:0]} for a WIDTH=w add or subtract.
    function automatic logic [9:0] ref_model(input int w, input int ua, input int ub,
                                             input int uc, input int us);
        int mod  = 1 << w;
        int half = 1 << (w - 1);
        int sa   = (ua >= half) ? ua - mod : ua;
        int sb   = (ub >= half) ? ub - mod : ub;
        int raw, sres;
        logic [7:0] s;
        logic co, ov;
        if (us != 0) begin
            raw  = ua - ub - uc;
            sres = sa - sb - uc;
            co   = (raw >= 0);
        end else begin
            raw  = ua + ub + uc;
            sres = sa + sb + uc;
            co   = (raw >= mod);
        end
        s  = 8'(((raw % mod) + mod) % mod);
        ov = (sres < -half) || (sres > half - 1);
        return {ov, co, s};
    endfunction

    function automatic int ns4(input int i);
        return (i == 0) ? 4 : ((i == 1) ? 2 : 1);
    endfunction

    // Entered and left just after a falling edge.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                          input logic ts, input logic [7:0] es, input logic ec,
                          input logic eo, input string tag);
        logic got;
        got = 1'b0;
        a = ta; b = tb_; cin = tc; sub = ts; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~ta; b = ~tb_; cin = ~tc;
        for (int k = 1; k <= N + 3; k++) begin
            if (!got) begin
                @(negedge clk);
                if (done) begin
                    got = 1'b1;
                    check({tag, "_latency"}, 32'(k), 32'(N));
                    check({tag, "_sum"}, 32'(sum), 32'(es));
                    check({tag, "_cout"}, 32'(cout), 32'(ec));
                    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
                    check({tag, "_ready_at_done"}, 32'(ready), 32'(1));
                end
            end
        end
        if (!got) check({tag, "_done_timeout"}, 32'(0), 32'(1));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'(0));
        check({tag, "_hold_sum"}, 32'(sum), 32'(es));
    endtask

    task automatic sweep_op(input int ua, input int ub, input int uc);
        logic seen [3];
        logic [9:0] e;
        e = ref_model(4, ua, ub, uc, 0);
        s4_a = 4'(ua); s4_b = 4'(ub); s4_cin = uc[0]; s4_start = 1'b1;
        @(negedge clk);
        s4_start = 1'b0; s4_a = ~s4_a; s4_b = ~s4_b;
        for (int i = 0; i < 3; i++) seen[i] = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (w_done[i]) begin
                    check("sweep_pulse", 32'(seen[i]), 32'(0));
                    check("sweep_latency", 32'(k), 32'(ns4(i)));
                    check("sweep_sum", 32'(w_sum[i]), 32'(e[3:0]));
                    check("sweep_cout", 32'(w_cout[i]), 32'(e[8]));
                    check("sweep_ovf", 32'(w_ovf[i]), 32'(e[9]));
                    seen[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < 3; i++) check("sweep_done_seen", 32'(seen[i]), 32'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] e;
        int ra, rb, rc, rs;

        vecs[0] = '{a: 8'h3C, b: 8'h45, cin: 1'b1, sum: 8'h82, cout: 1'b0, ovf: 1'b1};
        vecs[1] = '{a: 8'hFF, b: 8'h00, cin: 1'b1, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 8'h01, b: 8'h01, cin: 1'b0, sum: 8'h02, cout: 1'b0, ovf: 1'b0};
        vecs[3] = '{a: 8'h7F, b: 8'h00, cin: 1'b1, sum: 8'h80, cout: 1'b0, ovf: 1'b1};
        vecs[4] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1, ovf: 1'b0};
        vecs[5] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b1};

        // Reset with start held high: outputs at reset values before any clock.
        rst_n = 1'b0; start = 1'b1; a = 8'h3C; b = 8'h45;
        #1;
        check("rst_async_ready", 32'(ready), 32'(1));
        check("rst_async_done", 32'(done), 32'(0));
        check("rst_async_sum", 32'(sum), 32'(0));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_ready", 32'(ready), 32'(1));
            check("rst_done", 32'(done), 32'(0));
            check("rst_sum", 32'(sum), 32'(0));
            check("rst_cout", 32'(cout), 32'(0));
            check("rst_ovf", 32'(ovf), 32'(0));
        end
        rst_n = 1'b1; start = 1'b0;
        @(negedge clk);
        check("post_rst_idle", 32'(ready), 32'(1));

        // start held high: one accept every N+1 cycles, operand changes mid-run ignored.
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        for (int k = 0; k <= 14; k++) begin
            @(negedge clk);
            check("hold_ready", 32'(ready), 32'((k % 5) == 4));
            check("hold_done", 32'(done), 32'((k % 5) == 4));
            if (k == 4)  check("hold_sum1", 32'(sum), 32'(8'h46));
            if (k == 9)  check("hold_sum2", 32'(sum), 32'(8'hFF));
            if (k == 14) check("hold_sum3", 32'(sum), 32'(8'h02));
            if (k == 1)  begin a = 8'hAA; b = 8'h55; end
            if (k == 6)  begin a = 8'h01; b = 8'h01; end
            if (k == 11) begin a = 8'hF0; b = 8'h0F; end
            if (k == 14) start = 1'b0;
        end
        @(negedge clk);
        check("hold_end_ready", 32'(ready), 32'(1));
        check("hold_end_done", 32'(done), 32'(0));

        for (int i = 0; i < 6; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0,
                   vecs[i].sum, vecs[i].cout, vecs[i].ovf, "vec");

        // Reset after two RUN edges aborts the op.
        a = 8'h3C; b = 8'h45; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(ready), 32'(1));
        check("abort_done", 32'(done), 32'(0));
        check("abort_sum", 32'(sum), 32'(0));
        check("abort_cout", 32'(cout), 32'(0));
        check("abort_ovf", 32'(ovf), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'(0));
        end
        run_op(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, "after_abort");

`ifdef ADDER_SEQ_SUB_EN
        run_op(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, "sub");
`endif

        for (int r = 0; r < 40; r++) begin
            ra = int'($urandom_range(0, 255));
            rb = int'($urandom_range(0, 255));
            rc = int'($urandom_range(0, 1));
`ifdef ADDER_SEQ_SUB_EN
            rs = int'($urandom_range(0, 1));
`else
            rs = 0;
`endif
            e = ref_model(8, ra, rb, rc, rs);
            run_op(8'(ra), 8'(rb), rc[0], rs[0], e[7:0], e[8], e[9], "rand");
        end

        for (int ua = 0; ua < 16; ua++)
            for (int ub = 0; ub < 16; ub++)
                for (int uc = 0; uc < 2; uc++)
                    sweep_op(ua, ub, uc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_seq_nb.md
Name: adder_seq_nb

Overview:
- Parametrised multi-cycle ripple adder. It is the successor to the fixed 2-bit combinational adder.
- Adds two WIDTH-bit operands plus carry-in, SLICE bits per clock, with a start/ready/done handshake.
- Sits beside the datapath blocks in the arithmetic library. It trades latency for a small SLICE-bit carry chain.
- Result, carry-out and signed overflow are held until the next accepted operation.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be at least 1.
- SLICE, 2, bits added per cycle; must divide WIDTH exactly. SLICE = WIDTH gives single-slice operation.

Ports:
- clk  in  1  single system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only while ready=1.
- a  in  WIDTH  operand A; latched when start is accepted.
- b  in  WIDTH  operand B; latched when start is accepted.
- cin  in  1  carry-in; latched when start is accepted.
- ready  out  1  high when idle and able to accept start.
- done  out  1  one-cycle pulse; sum, cout and ovf are valid from this cycle.
- sum  out  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.
- ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values, applied immediately on rst_n=0 with no clock needed:
  - state=IDLE, ready=1, done=0.
  - sum=0, cout=0, ovf=0.
  - internal operand registers, carry register and slice index all 0.
- N = WIDTH/SLICE. Slice index width is clog2(N), minimum 1.
- FSM states:
  - IDLE: ready=1. Transitions to RUN on start=1. On that edge a, b and cin are latched, the slice index is set to 0 and sum is cleared.
  - RUN: ready=0. Each edge adds slice k of A and B plus the carry register, writes sum[k*SLICE +: SLICE], updates the carry register and increments k.
  - Leaving RUN: on the edge computing slice N-1, cout and ovf are registered, done is set to 1 and state returns to IDLE.
- Latency: start accepted at edge T gives done=1 during the cycle after edge T+N. Done is never held for more than one cycle.
- Back-to-back operation: ready=1 during the done cycle. A start in that cycle is accepted, so the throughput is one result per N+1 cycles.
- Result hold: sum, cout and ovf hold their value after done.
  - They change only when the next start is accepted; sum clears to 0 at that point.
  - Partial sums are visible during RUN; only the done cycle and later are guaranteed.
- start=1 while ready=0 is ignored. It is neither queued nor allowed to corrupt the operation in flight.
- Operand changes on a, b or cin during RUN have no effect.
- Reset asserted mid-RUN aborts the operation. All outputs go to reset values and no done is produced.
- ovf is computed from the carry into and out of bit WIDTH-1 within the final slice.
- WIDTH=1, SLICE=1: N=1, and done follows the cycle after one RUN edge.

Optional Feature:
- Macro: ADDER_SEQ_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), latched with the operands.
  - sub=1 computes a - b - cin: the B register is loaded with ~b and the carry register with ~cin.
  - cout is then the inverted borrow, so cout=1 means no borrow.
  - ovf is signed overflow of the subtraction.
- When undefined:
  - No sub port exists and only addition is performed.
  - Logic is identical to the sub=0 path.

Decomposition:
- Package adder_seq_pkg holds:
  - state enum IDLE/RUN;
  - function n_slices(WIDTH, SLICE);
  - function idx_w(n), returning clog2 with a minimum of 1.
- Elaboration check (in the package or in the module): WIDTH % SLICE == 0 and SLICE ≥ 1.
- One natural sub-module: adder_slice, a combinational SLICE-bit ripple adder. Its outputs are s, c_out and c_msb_in (carry into the slice MSB, used for ovf).
- adder_seq_nb holds the FSM, the registers and one adder_slice instance.

Test Plan:
- Reset: rst_n low for 3 cycles with start=1 → ready=1, done=0, sum=0x00, cout=0, ovf=0; start not accepted while rst_n low.
- Basic add, WIDTH=8, SLICE=2:
  - Stimulus: a=0x3C, b=0x45, cin=1, start pulse at edge T.
  - Required: done only in the cycle after edge T+4; sum=0x82, cout=0, ovf=1.
- Full carry ripple: a=0xFF, b=0x00, cin=1 → sum=0x00, cout=1, ovf=0; a=0x80, b=0x80, cin=0 → sum=0x00, cout=1, ovf=1.
- Handshake:
  - start held high continuously → accepted every 5 cycles, with ready=0 for 4 cycles between.
  - Change a and b mid-RUN → result still matches the latched operands.
- Reset mid-RUN: assert rst_n=0 after 2 RUN edges → outputs cleared, no done; a new op 0x01+0x01 then gives sum=0x02.
- Sweep: exhaustive 4-bit (WIDTH=4, SLICE ∈ {1,2,4}) for all a, b and cin against a reference model.
  - With ADDER_SEQ_SUB_EN: 0x05-0x07, cin=0 → sum=0xFE, cout=0.
